// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential radix-2 shift-and-add multiplier, one partial product per clock
// Optional two's-complement operation when MULT_SIGNED_EN is defined.
module shift_add_multiplier #(
  parameter int SIZE = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iStart,
  input  logic [SIZE-1:0]     iA,
  input  logic [SIZE-1:0]     iB,
  output logic                oBusy,
  output logic                oDone,
  output logic [2*SIZE-1:0]   oResult
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_next;
  logic [SIZE-1:0]     mcand, mplier, acc_hi;
  logic [CW-1:0]       cnt;
  logic                capture, last_step;
  logic [SIZE:0]       sum;
  logic [2*SIZE-1:0]   product, final_product;
  logic [SIZE-1:0]     a_mag, b_mag;

  // Accumulator upper half plus optional multiplicand; carry is kept in sum[SIZE]
  assign sum       = {1'b0, acc_hi} + ({1'b0, mcand} & {(SIZE+1){mplier[0]}});
  assign product   = {sum, mplier[SIZE-1:1]};
  assign last_step = (cnt == CW'(SIZE-1));

`ifdef MULT_SIGNED_EN
  logic sign;
  assign a_mag         = iA[SIZE-1] ? -iA : iA;
  assign b_mag         = iB[SIZE-1] ? -iB : iB;
  assign final_product = sign ? -product : product;
`else
  assign a_mag         = iA;
  assign b_mag         = iB;
  assign final_product = product;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: if (iStart) begin
        capture    = 1'b1;
        state_next = CALC;
      end
      CALC: if (last_step) state_next = DONE;
      DONE: begin
        if (iStart) begin
          capture    = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      cnt     <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
`ifdef MULT_SIGNED_EN
      sign    <= 1'b0;
`endif
    end else begin
      oBusy <= (state_next == CALC);
      oDone <= (state_next == DONE);
      if (capture) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        acc_hi <= '0;
        cnt    <= '0;
`ifdef MULT_SIGNED_EN
        sign   <= iA[SIZE-1] ^ iB[SIZE-1];
`endif
      end else if (state == CALC) begin
        acc_hi <= sum[SIZE:1];
        mplier <= {sum[0], mplier[SIZE-1:1]};
        cnt    <= cnt + CW'(1);
        if (last_step) oResult <= final_product;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int SIZE = 16;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              iStart;
  logic [SIZE-1:0]   iA, iB;
  logic              oBusy, oDone;
  logic [2*SIZE-1:0] oResult;

  typedef struct {
    logic [2*SIZE-1:0] res;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  shift_add_multiplier #(.SIZE(SIZE)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .iStart (iStart),
    .iA     (iA),
    .iB     (iB),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oResult(oResult)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*SIZE-1:0] act, input logic [2*SIZE-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every oDone pops one expected product and its expected completion cycle
  always @(negedge Clock) begin
    if (oDone) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got oResult 0x%0h expected no oDone (cycle %0d)", oResult, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", oResult, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_low_in_done", {31'b0, oBusy}, 32'd0);
      end
    end
  end

  task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic [2*SIZE-1:0] r);
    exp_t e;
    iStart = 1'b1;
    iA     = a;
    iB     = b;
    e.res  = r;
    e.cyc  = cyc + 1 + SIZE;
    sb.push_back(e);
    @(negedge Clock);
    iStart = 1'b0;
    iA     = SIZE'($urandom);
    iB     = SIZE'($urandom);
    check("busy_after_capture", {31'b0, oBusy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge Clock);
  endtask

  initial begin
    int c1;
    exp_t e;
    Reset  = 1'b0;
    iStart = 1'b0;
    iA     = '0;
    iB     = '0;
    #2;
    check("reset_busy", {31'b0, oBusy}, 32'd0);
    check("reset_done", {31'b0, oDone}, 32'd0);
    check("reset_result", oResult, 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    start_op(16'h0003, 16'h0005, 32'h0000000F);
    wait_idle();
    start_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    wait_idle();
    start_op(16'h1234, 16'h0000, 32'h00000000);
    wait_idle();
    start_op(16'h00AB, 16'h0100, 32'h0000AB00);
    wait_idle();

    // Start while busy is ignored
    start_op(16'h0002, 16'h0003, 32'h00000006);
    repeat (7) @(negedge Clock);
    iStart = 1'b1;
    iA     = 16'h00FF;
    iB     = 16'h00FF;
    @(negedge Clock);
    iStart = 1'b0;
    wait_idle();
    repeat (20) @(negedge Clock);

    // Back-to-back with iStart held high
    iStart = 1'b1;
    iA     = 16'h0010;
    iB     = 16'h0010;
    c1     = cyc + 1;
    e.res  = 32'h00000100; e.cyc = c1 + SIZE;          sb.push_back(e);
    e.res  = 32'h00010000; e.cyc = c1 + SIZE + 1 + SIZE; sb.push_back(e);
    @(negedge Clock);
    iA = 16'h0100;
    iB = 16'h0100;
    repeat (17) @(negedge Clock);
    iStart = 1'b0;
    repeat (3) @(negedge Clock);
    check("hold_first_result", oResult, 32'h00000100);
    check("busy_second_op", {31'b0, oBusy}, 32'd1);
    wait_idle();
    check("second_result_held", oResult, 32'h00010000);

    // Reset mid-operation
    iStart = 1'b1;
    iA     = 16'h0003;
    iB     = 16'h0005;
    @(negedge Clock);
    iStart = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, oBusy}, 32'd0);
    check("abort_done", {31'b0, oDone}, 32'd0);
    check("abort_result", oResult, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (25) @(negedge Clock);
    check("abort_result_after", oResult, 32'd0);
    check("abort_busy_after", {31'b0, oBusy}, 32'd0);

`ifdef MULT_SIGNED_EN
    start_op(16'hFFFF, 16'h0002, 32'hFFFFFFFE);
    wait_idle();
    start_op(16'h8000, 16'h8000, 32'h40000000);
    wait_idle();
    start_op(16'h8000, 16'h0001, 32'hFFFF8000);
    wait_idle();
    start_op(16'hFFFD, 16'h0000, 32'h00000000);
    wait_idle();
`else
    start_op(16'h8000, 16'h0002, 32'h00010000);
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
